seg_display_arbiter: RTL

Shares the cart's single 4-digit seven-segment display between three requesters: channel 0 is alert/status, channel 1 is sensor distance, and channel 2 is speed/mode. The block grants the display round-robin with a minimum hold time per owner, and lets channel 0 preempt. It drives the 16-bit BCD/code word (`nums`) that feeds the seven-segment scan driver. Codes 10 (dash) and 11 (blank) keep the driver's meaning.

---
 rtl/seg_display_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: round-robin owner of the shared 4-digit seven-segment
// display, with a minimum hold time per owner and channel 0 preemption.
// Optional feature macro: SEG_ARB_BLINK_EN (channel 0 blinks while it owns
// the display). With the macro undefined, val0 is shown steadily.
module seg_display_arbiter #(
   parameter int unsigned TICK_DIV = 100000,
   parameter int unsigned HOLD_MS  = 1000,
   parameter int unsigned BLINK_MS = 250
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  req,
   input  logic [15:0] val0,
   input  logic [15:0] val1,
   input  logic [15:0] val2,
   output logic [2:0]  gnt,
   output logic [15:0] nums,
   output logic        busy
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned HW = (HOLD_MS > 1) ? $clog2(HOLD_MS + 1) : 1;
   localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MS - 1);
   localparam logic [15:0] DASHES = 16'hAAAA;
   localparam logic [15:0] BLANKS = 16'hBBBB;

   typedef enum logic {IDLE, SHOW} state_t;

   state_t        state;
   logic [1:0]    owner;
   logic [PW-1:0] pre;
   logic [HW-1:0] hold;

   logic          tick;
   logic          expire;
   logic          cur_req;
   logic          rr_found;
   logic [1:0]    rr_idx;
   logic [1:0]    low_idx;
   logic          nxt_show;
   logic [1:0]    nxt_owner;
   logic          change;
   logic          restart;
   logic [15:0]   nxt_val;
   logic [2:0]    nxt_gnt;

`ifdef SEG_ARB_BLINK_EN
   localparam int unsigned BW = (BLINK_MS > 1) ? $clog2(BLINK_MS + 1) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MS - 1);
   logic [BW-1:0] blink_cnt;
   logic          blank;
   logic          blank_nxt;
`endif

   // Time base and the next round-robin candidate after the current owner.
   always_comb begin
      tick     = (state == SHOW) && (pre == PRE_LAST);
      expire   = tick && (hold == HOLD_LAST);
      cur_req  = 1'b0;
      rr_found = 1'b0;
      rr_idx   = owner;
      case (owner)
         2'd1: begin
            cur_req = req[1];
            if (req[2])      begin rr_found = 1'b1; rr_idx = 2'd2; end
            else if (req[0]) begin rr_found = 1'b1; rr_idx = 2'd0; end
         end
         2'd2: begin
            cur_req = req[2];
            if (req[0])      begin rr_found = 1'b1; rr_idx = 2'd0; end
            else if (req[1]) begin rr_found = 1'b1; rr_idx = 2'd1; end
         end
         default: begin
            cur_req = req[0];
            if (req[1])      begin rr_found = 1'b1; rr_idx = 2'd1; end
            else if (req[2]) begin rr_found = 1'b1; rr_idx = 2'd2; end
         end
      endcase
      if (req[0])      low_idx = 2'd0;
      else if (req[1]) low_idx = 2'd1;
      else             low_idx = 2'd2;
   end

   // Ownership decision: preempt, then drop, then hold expiry.
   always_comb begin
      nxt_show  = (state == SHOW);
      nxt_owner = owner;
      change    = 1'b0;
      restart   = 1'b0;
      if (state == IDLE) begin
         if (|req) begin
            nxt_show  = 1'b1;
            nxt_owner = low_idx;
            change    = 1'b1;
         end
      end else if ((owner != 2'd0) && req[0]) begin
         nxt_owner = 2'd0;
         change    = 1'b1;
      end else if (!cur_req) begin
         change = 1'b1;
         if (rr_found) nxt_owner = rr_idx;
         else          nxt_show  = 1'b0;
      end else if (expire) begin
         if (rr_found) begin
            nxt_owner = rr_idx;
            change    = 1'b1;
         end else begin
            restart = 1'b1;
         end
      end
   end

   // Next displayed word and one-hot grant.
   always_comb begin
      case (nxt_owner)
         2'd1:    begin nxt_val = val1; nxt_gnt = 3'b010; end
         2'd2:    begin nxt_val = val2; nxt_gnt = 3'b100; end
         default: begin nxt_val = val0; nxt_gnt = 3'b001; end
      endcase
      if (!nxt_show) nxt_gnt = 3'b000;
   end

`ifdef SEG_ARB_BLINK_EN
   // Blink phase for the next cycle; every grant starts in the visible phase.
   always_comb begin
      blank_nxt = blank;
      if (change)                                blank_nxt = 1'b0;
      else if (tick && (blink_cnt == BLINK_LAST)) blank_nxt = ~blank;
   end

   // Blink counter: counts ticks since the grant, toggling the phase on terminal count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_cnt <= '0;
         blank     <= 1'b0;
      end else begin
         blank <= blank_nxt;
         if (change)                          blink_cnt <= '0;
         else if (tick && (blink_cnt == BLINK_LAST)) blink_cnt <= '0;
         else if (tick)                       blink_cnt <= blink_cnt + BW'(1);
      end
   end
`endif

   // Arbiter state, counters and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         owner <= 2'd0;
         pre   <= '0;
         hold  <= '0;
         gnt   <= 3'b000;
         nums  <= DASHES;
         busy  <= 1'b0;
      end else begin
         state <= nxt_show ? SHOW : IDLE;
         owner <= nxt_owner;
         if (change || restart) begin
            pre  <= '0;
            hold <= '0;
         end else if (state == SHOW) begin
            if (tick) begin
               pre  <= '0;
               hold <= hold + HW'(1);
            end else begin
               pre <= pre + PW'(1);
            end
         end
         gnt  <= nxt_gnt;
         busy <= nxt_show;
         if (!nxt_show) nums <= DASHES;
`ifdef SEG_ARB_BLINK_EN
         else if ((nxt_owner == 2'd0) && blank_nxt) nums <= BLANKS;
`endif
         else nums <= nxt_val;
      end
   end

endmodule
